serial_rx: RTL and testbench

- Receive half of the EMC08 serial port; peer of serial_tx. Shares the baud source serial_br_i and SCON mode bits with it.
- Mode 0 (SM0=0): synchronous 8-bit shift-in. Data enters on P3.0 (RXD); the block drives the shift clock on P3.1.
- Mode 1 (SM0=1): asynchronous 11-bit frame (start, 8 data, 9th bit, stop) with 16x oversampling.
- Delivers a received byte to SBUF with RB8 and an RI set strobe to the SFR block.

---
 rtl/serial_rx_pkg.sv | 28 ++
 rtl/serial_rx_sampler.sv | 40 ++++
 rtl/serial_rx.sv | 181 ++++++++++++++++++
 tb/tb_serial_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared constants for the serial port receive path: state encodings,
// oversampling sample points and the SCON.SM0 mode encodings used with serial_tx.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_M0_SHIFT = 3'd1,
    RX_M1_START = 3'd2,
    RX_M1_DATA  = 3'd3,
    RX_M1_BIT9  = 3'd4,
    RX_M1_STOP  = 3'd5,
    RX_WAIT_RI  = 3'd6
  } rx_state_t;

  localparam int SER_OVERSAMPLE = 16;
  localparam int SER_SMP_A      = 7;
  localparam int SER_SMP_B      = 8;
  localparam int SER_SMP_C      = 9;
  localparam int SER_CNT_LAST   = SER_OVERSAMPLE - 1;

  localparam logic MODE_SYNC  = 1'b0;
  localparam logic MODE_ASYNC = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_sampler.sv
// RXD conditioning: 2-flop synchronizer, falling-edge detect and the
// 3-sample majority vote taken at oversample counts 7/8/9.
module serial_rx_sampler
  import serial_rx_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             serial_clock_i,
  input  logic             serial_reset_i_b,
  input  logic             serial_rxd_i,
  input  logic             tick,
  input  logic [CNT_W-1:0] cnt,
  output logic             rxd_s,
  output logic             fall,
  output logic             maj,
  output logic             sample_valid
);

  // [0],[1] synchronizer, [2] edge-detect delay; idle line is high
  logic [2:0] sync_q;
  logic       smp_a, smp_b;

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      sync_q <= 3'b111;
      smp_a  <= 1'b0;
      smp_b  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], serial_rxd_i};
      if (tick && cnt == CNT_W'(SER_SMP_A)) smp_a <= sync_q[1];
      if (tick && cnt == CNT_W'(SER_SMP_B)) smp_b <= sync_q[1];
    end
  end

  assign rxd_s        = sync_q[1];
  assign fall         = sync_q[2] & ~sync_q[1];
  assign sample_valid = tick && (cnt == CNT_W'(SER_SMP_C));
  assign maj          = maj3(smp_a, smp_b, sync_q[1]);

endmodule

// File: rtl/serial_rx.sv
// Serial port receiver: mode 0 synchronous shift-in driving P3.1, mode 1
// 11-bit asynchronous frame with 16x oversampling and multiprocessor filter.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int OVERSAMPLE = SER_OVERSAMPLE,
  parameter int DATA_W     = 8
) (
  input  logic              serial_clock_i,
  input  logic              serial_reset_i_b,
  input  logic              serial_br_i,
  input  logic              serial_scon7_sm0_i,
  input  logic              serial_scon5_sm2_i,
  input  logic              serial_scon4_ren_i,
  input  logic              serial_scon0_ri_i,
  input  logic              serial_rxd_i,
  output logic [DATA_W-1:0] serial_data_sbuf_o,
  output logic              serial_scon2_rb8_o,
  output logic              serial_scon0_ri_o,
  output logic              serial_load_o,
  output logic              serial_frame_err_o,
  output logic              serial_clk_o,
  output logic              serial_p3en_1_o,
  output logic              serial_busy_o
);

  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_W + 1);

  rx_state_t         st, st_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BCNT_W-1:0] bcnt, bcnt_n;
  logic [DATA_W-1:0] sh, sh_n, sbuf_n;
  logic              bit9, bit9_n, rb8_n, ri_n, load_n, ferr_n, clk_n, p3en_n;
  logic              br_q, tick, rxd_s, fall, maj, sample_valid, cnt_last;

  assign tick     = serial_br_i & ~br_q;
  assign cnt_last = (cnt == CNT_W'(OVERSAMPLE - 1));

  serial_rx_sampler #(.CNT_W(CNT_W)) u_sampler (
    .serial_clock_i   (serial_clock_i),
    .serial_reset_i_b (serial_reset_i_b),
    .serial_rxd_i     (serial_rxd_i),
    .tick             (tick),
    .cnt              (cnt),
    .rxd_s            (rxd_s),
    .fall             (fall),
    .maj              (maj),
    .sample_valid     (sample_valid)
  );

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      st                 <= RX_IDLE;
      cnt                <= '0;
      bcnt               <= '0;
      sh                 <= '0;
      bit9               <= 1'b0;
      br_q               <= 1'b0;
      serial_data_sbuf_o <= '0;
      serial_scon2_rb8_o <= 1'b0;
      serial_scon0_ri_o  <= 1'b0;
      serial_load_o      <= 1'b0;
      serial_frame_err_o <= 1'b0;
      serial_clk_o       <= 1'b1;
      serial_p3en_1_o    <= 1'b0;
      serial_busy_o      <= 1'b0;
    end else begin
      st                 <= st_n;
      cnt                <= cnt_n;
      bcnt               <= bcnt_n;
      sh                 <= sh_n;
      bit9               <= bit9_n;
      br_q               <= serial_br_i;
      serial_data_sbuf_o <= sbuf_n;
      serial_scon2_rb8_o <= rb8_n;
      serial_scon0_ri_o  <= ri_n;
      serial_load_o      <= load_n;
      serial_frame_err_o <= ferr_n;
      serial_clk_o       <= clk_n;
      serial_p3en_1_o    <= p3en_n;
      serial_busy_o      <= (st_n != RX_IDLE);
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    bcnt_n = bcnt;
    sh_n   = sh;
    bit9_n = bit9;
    sbuf_n = serial_data_sbuf_o;
    rb8_n  = serial_scon2_rb8_o;
    ri_n   = 1'b0;
    load_n = 1'b0;
    ferr_n = 1'b0;
    clk_n  = serial_clk_o;
    p3en_n = serial_p3en_1_o;
    case (st)
      RX_IDLE: begin
        clk_n  = 1'b1;
        p3en_n = 1'b0;
        if (serial_scon7_sm0_i == MODE_SYNC && serial_scon4_ren_i && !serial_scon0_ri_i && tick) begin
          st_n   = RX_M0_SHIFT;
          clk_n  = 1'b0;
          p3en_n = 1'b1;
          bcnt_n = '0;
        end else if (serial_scon7_sm0_i == MODE_ASYNC && serial_scon4_ren_i && fall) begin
          st_n  = RX_M1_START;
          cnt_n = '0;
        end
      end
      RX_M0_SHIFT: begin
        if (!serial_scon4_ren_i || serial_scon7_sm0_i != MODE_SYNC) begin
          st_n   = RX_IDLE;
          clk_n  = 1'b1;
          p3en_n = 1'b0;
        end else if (tick) begin
          if (bcnt == BCNT_W'(DATA_W)) begin
            sbuf_n = sh;
            ri_n   = 1'b1;
            load_n = 1'b1;
            clk_n  = 1'b1;
            p3en_n = 1'b0;
            st_n   = RX_WAIT_RI;
          end else begin
            clk_n = ~serial_clk_o;
            // shift on the low-to-high edge of the shift clock
            if (!serial_clk_o) begin
              sh_n   = {rxd_s, sh[DATA_W-1:1]};
              bcnt_n = bcnt + 1'b1;
            end
          end
        end
      end
      RX_M1_START, RX_M1_DATA, RX_M1_BIT9, RX_M1_STOP: begin
        if (serial_scon7_sm0_i != MODE_ASYNC) begin
          st_n = RX_IDLE;
        end else if (tick) begin
          cnt_n = cnt_last ? '0 : cnt + 1'b1;
          case (st)
            RX_M1_START: begin
              if (sample_valid && maj) st_n = RX_IDLE;
              else if (cnt_last) begin
                st_n   = RX_M1_DATA;
                bcnt_n = '0;
              end
            end
            RX_M1_DATA: begin
              if (sample_valid) begin
                sh_n   = {maj, sh[DATA_W-1:1]};
                bcnt_n = bcnt + 1'b1;
              end
              if (cnt_last && bcnt == BCNT_W'(DATA_W)) st_n = RX_M1_BIT9;
            end
            RX_M1_BIT9: begin
              if (sample_valid) bit9_n = maj;
              if (cnt_last) st_n = RX_M1_STOP;
            end
            default: begin
              // decide at the stop midpoint so a new start edge is caught early
              if (sample_valid) begin
                if (!serial_scon0_ri_i && (!serial_scon5_sm2_i || bit9)) begin
                  sbuf_n = sh;
                  rb8_n  = bit9;
                  ri_n   = 1'b1;
                  load_n = 1'b1;
                end
                ferr_n = ~maj;
                st_n   = RX_IDLE;
              end
            end
          endcase
        end
      end
      RX_WAIT_RI: if (serial_scon0_ri_i) st_n = RX_IDLE;
      default: st_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: mode 0 shift-in, mode 1 frames, false start,
// multiprocessor filter, blocked load, frame error and reset mid-frame.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       br = 1'b0, sm0 = 1'b0, sm2 = 1'b0, ren = 1'b0, ri_i = 1'b0, rxd = 1'b1;
  logic [7:0] sbuf;
  logic       rb8, ri_o, load_o, ferr_o, clk_o, p3en_o, busy_o;

  int n_cmp = 0, n_bad = 0;
  int ri_cnt = 0, ld_cnt = 0, fe_cnt = 0, rise_cnt = 0, p3en_clks = 0;
  int ri0, ld0, fe0, rise0, p3en0;
  logic clk_o_prev = 1'b1;

  always #5 clk = ~clk;

  serial_rx dut (
    .serial_clock_i     (clk),
    .serial_reset_i_b   (rst_n),
    .serial_br_i        (br),
    .serial_scon7_sm0_i (sm0),
    .serial_scon5_sm2_i (sm2),
    .serial_scon4_ren_i (ren),
    .serial_scon0_ri_i  (ri_i),
    .serial_rxd_i       (rxd),
    .serial_data_sbuf_o (sbuf),
    .serial_scon2_rb8_o (rb8),
    .serial_scon0_ri_o  (ri_o),
    .serial_load_o      (load_o),
    .serial_frame_err_o (ferr_o),
    .serial_clk_o       (clk_o),
    .serial_p3en_1_o    (p3en_o),
    .serial_busy_o      (busy_o)
  );

  // strobe and shift-clock activity, sampled on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (ri_o)   ri_cnt++;
      if (load_o) ld_cnt++;
      if (ferr_o) fe_cnt++;
      if (p3en_o) p3en_clks++;
      if (clk_o && !clk_o_prev) rise_cnt++;
    end
    clk_o_prev = clk_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one baud tick = 8 clocks, br high for the first 4
  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      br = 1'b1;
      repeat (4) @(negedge clk);
      br = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    do_tick(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b9, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(b9);
    send_bit(stp);
    rxd = 1'b1;
    do_tick(4);
  endtask

  task automatic snap();
    ri0 = ri_cnt; ld0 = ld_cnt; fe0 = fe_cnt; rise0 = rise_cnt; p3en0 = p3en_clks;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sbuf"}, 32'(sbuf), 32'h00);
    chk({tag, "_rb8"}, 32'(rb8), 32'd0);
    chk({tag, "_strobes"}, {29'd0, ri_o, load_o, ferr_o}, 32'd0);
    chk({tag, "_clk_o"}, 32'(clk_o), 32'd1);
    chk({tag, "_p3en"}, 32'(p3en_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [7:0] m0_data;
    m0_data = 8'hA5;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // mode 0: bit i presented before its clk_o rising tick
    sm0 = 1'b0; ren = 1'b1; ri_i = 1'b0;
    snap();
    for (int i = 0; i < 8; i++) begin
      rxd = m0_data[i];
      do_tick(2);
    end
    do_tick(1);
    chk("m0_rises", 32'(rise_cnt - rise0), 32'd8);
    chk("m0_p3en_clks", 32'(p3en_clks - p3en0), 32'd128);
    chk("m0_sbuf", 32'(sbuf), 32'hA5);
    chk("m0_ri", 32'(ri_cnt - ri0), 32'd1);
    chk("m0_load", 32'(ld_cnt - ld0), 32'd1);
    do_tick(3);
    chk("m0_busy_wait", 32'(busy_o), 32'd1);
    ri_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("m0_busy_done", 32'(busy_o), 32'd0);
    sm0 = 1'b1;
    repeat (2) @(negedge clk);
    ri_i = 1'b0;
    rxd = 1'b1;
    do_tick(4);

    // mode 1 basic frame
    snap();
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("m1_sbuf", 32'(sbuf), 32'h3C);
    chk("m1_rb8", 32'(rb8), 32'd1);
    chk("m1_ri", 32'(ri_cnt - ri0), 32'd1);
    chk("m1_ferr", 32'(fe_cnt - fe0), 32'd0);

    // false start
    snap();
    rxd = 1'b0; do_tick(4);
    rxd = 1'b1; do_tick(16);
    chk("fs_strobes", 32'((ri_cnt - ri0) + (ld_cnt - ld0) + (fe_cnt - fe0)), 32'd0);
    chk("fs_sbuf", 32'(sbuf), 32'h3C);
    chk("fs_busy", 32'(busy_o), 32'd0);

    // multiprocessor filtering
    sm2 = 1'b1;
    snap();
    send_frame(8'h55, 1'b0, 1'b1);
    chk("mp0_ri", 32'(ri_cnt - ri0), 32'd0);
    chk("mp0_sbuf", 32'(sbuf), 32'h3C);
    snap();
    send_frame(8'h55, 1'b1, 1'b1);
    chk("mp1_sbuf", 32'(sbuf), 32'h55);
    chk("mp1_rb8", 32'(rb8), 32'd1);
    chk("mp1_ri", 32'(ri_cnt - ri0), 32'd1);
    sm2 = 1'b0;

    // RI still set blocks the load
    ri_i = 1'b1;
    snap();
    send_frame(8'h12, 1'b0, 1'b1);
    chk("blk_ri", 32'(ri_cnt - ri0), 32'd0);
    chk("blk_load", 32'(ld_cnt - ld0), 32'd0);
    chk("blk_sbuf", 32'(sbuf), 32'h55);
    ri_i = 1'b0;

    // stop bit low: loads and flags a frame error
    snap();
    send_frame(8'h81, 1'b0, 1'b0);
    chk("fe_sbuf", 32'(sbuf), 32'h81);
    chk("fe_rb8", 32'(rb8), 32'd0);
    chk("fe_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_ri", 32'(ri_cnt - ri0), 32'd1);

    // reset after three data bits
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("midrst");
    rst_n = 1'b1;
    do_tick(4);
    snap();
    send_frame(8'h0F, 1'b0, 1'b1);
    chk("post_sbuf", 32'(sbuf), 32'h0F);
    chk("post_rb8", 32'(rb8), 32'd0);
    chk("post_ri", 32'(ri_cnt - ri0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
